div24_seq: RTL

Sequential signed 24-bit divider for the ALU, the inverse-direction counterpart to the 24-bit carry-select adder. It performs one restoring subtract-and-shift step per clock on operand magnitudes, applies a sign fix-up, and returns quotient and remainder under a start/done handshake. It sits beside the adder in the ALU execute path and holds the pipeline through `busy` while an operation is in flight.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/sub25.sv | 42 ++++
 rtl/div24_seq.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU definitions. Holds the divider width, the
//               iteration counter width and the divider state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int DIV_W     = 24;  // divider operand / result width
    localparam int DIV_CNT_W = 5;   // counts DIV_W-1 down to 0

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/sub25.sv
`default_nettype none
// ============================================================================
// Module      : sub25
// Description : Combinational W-bit subtractor (default DIV_W+1 = 25 bits),
//               carry-select style: the low half ripples, the high half is
//               computed for both carry-ins and selected by the low carry.
// Ports       : i_a          minuend
//               i_b          subtrahend
//               o_diff       i_a - i_b, modulo 2^W
//               o_no_borrow  1 when i_a >= i_b (unsigned)
// Revision    : 1.0 - initial release
// ============================================================================
module sub25
    import alu_pkg::*;
#(
    parameter int W = DIV_W + 1
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_diff,
    output logic         o_no_borrow
);

    localparam int LO = W / 2;
    localparam int HI = W - LO;

    logic [LO:0] w_lo;
    logic [HI:0] w_hi0;
    logic [HI:0] w_hi1;
    logic [HI:0] w_hi;

    // a - b = a + ~b + 1; the +1 is the carry-in of the low block.
    assign w_lo  = {1'b0, i_a[LO-1:0]} + {1'b0, ~i_b[LO-1:0]} + {{LO{1'b0}}, 1'b1};
    assign w_hi0 = {1'b0, i_a[W-1:LO]} + {1'b0, ~i_b[W-1:LO]};
    assign w_hi1 = {1'b0, i_a[W-1:LO]} + {1'b0, ~i_b[W-1:LO]} + {{HI{1'b0}}, 1'b1};
    assign w_hi  = w_lo[LO] ? w_hi1 : w_hi0;

    assign o_diff      = {w_hi[HI-1:0], w_lo[LO-1:0]};
    assign o_no_borrow = w_hi[HI];

endmodule : sub25
`default_nettype wire

// File: rtl/div24_seq.sv
`default_nettype none
// ============================================================================
// Module      : div24_seq
// Description : Sequential signed divider, one restoring step per clock on
//               operand magnitudes followed by a sign fix-up cycle.
// Ports       : clk, rst      clock, asynchronous active-high reset
//               start         request, accepted when busy = 0
//               op1, op2      signed dividend / divisor
//               busy          operation in flight
//               done          one-cycle result-valid pulse
//               quotient      signed quotient, truncated toward zero
//               remainder     signed remainder, sign of dividend
//               div_zero      divisor was zero
// Revision    : 1.0 - initial release
// ============================================================================
module div24_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CNT_W = (WIDTH == DIV_W) ? DIV_CNT_W : $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dq;       // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] r_dvs;      // divisor magnitude
    logic [WIDTH-1:0] r_part;     // partial remainder (always < divisor)
    logic             r_sign1;
    logic             r_sign2;
    logic             r_dz;       // current operation is a divide by zero
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_div_zero;

    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_carry;
    logic             w_nb;

    // Magnitude of the most negative value is 2^(WIDTH-1), still representable unsigned.
    assign w_mag1 = op1[WIDTH-1] ? (~op1 + 1'b1) : op1;
    assign w_mag2 = op2[WIDTH-1] ? (~op2 + 1'b1) : op2;

    assign w_shift = {r_part, r_dq[WIDTH-1]};

    sub25 #(
        .W (WIDTH + 1)
    ) u_sub (
        .i_a         (w_shift),
        .i_b         ({1'b0, r_dvs}),
        .o_diff      (w_diff),
        .o_no_borrow (w_carry)
    );

    // A successful trial always lands below the divisor, so its top bit is
    // zero; requiring that keeps the accepted result within r_part.
    assign w_nb = w_carry & ~w_diff[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= DIV_IDLE;
            r_cnt      <= '0;
            r_dq       <= '0;
            r_dvs      <= '0;
            r_part     <= '0;
            r_sign1    <= 1'b0;
            r_sign2    <= 1'b0;
            r_dz       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                DIV_IDLE, DIV_DONE: begin
                    if (start) begin
                        r_busy     <= 1'b1;
                        r_sign1    <= op1[WIDTH-1];
                        r_sign2    <= op2[WIDTH-1];
                        r_cnt      <= C_CNT_LAST;
                        r_part     <= '0;
                        r_div_zero <= 1'b0;
                        if (op2 == '0) begin
                            // Raw dividend is parked in r_dq and returned as the remainder.
                            r_dz    <= 1'b1;
                            r_dq    <= op1;
                            r_dvs   <= '0;
                            r_state <= DIV_FIX;
                        end else begin
                            r_dz    <= 1'b0;
                            r_dq    <= w_mag1;
                            r_dvs   <= w_mag2;
                            r_state <= DIV_CALC;
                        end
                    end else begin
                        r_state <= DIV_IDLE;
                    end
                end
                DIV_CALC: begin
                    r_part <= w_nb ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                    r_dq   <= {r_dq[WIDTH-2:0], w_nb};
                    if (r_cnt == '0) begin
                        r_state <= DIV_FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DIV_FIX: begin
                    if (r_dz) begin
                        r_quot <= '1;
                        r_rem  <= r_dq;
                    end else begin
                        r_quot <= (r_sign1 ^ r_sign2) ? (~r_dq + 1'b1) : r_dq;
                        r_rem  <= r_sign1 ? (~r_part + 1'b1) : r_part;
                    end
                    r_div_zero <= r_dz;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                    r_state    <= DIV_DONE;
                end
                default: begin
                    r_state <= DIV_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign div_zero  = r_div_zero;

endmodule : div24_seq
`default_nettype wire
